// File: rtl/shift_sequencer.sv
// shift_sequencer: drives an 8-bit rotator through up to two passes to realise sll/srl/sra/ror.
// Define SHIFT_ZERO_FLAG_EN to register a RESULT==0 flag on ZERO; otherwise ZERO is tied low.
module shift_sequencer (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] OPERAND,
  input  logic [7:0] AMOUNT,
  input  logic [7:0] ROT_RESULT,
  output logic [7:0] ROT_DATA,
  output logic [2:0] ROT_S,
  output logic       ROT_A,
  output logic       ROT_C,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RESULT,
  output logic       ZERO
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, FIN} state_t;
  state_t state_q, state_d;
  logic [7:0] work_q, work_d, result_q, result_d;
  logic [2:0] s_q, s_d;
  logic a_q, a_d, c_q, c_d, two_q, two_d, sll_q, sll_d, done_q, done_d;
  logic accept, op_sll, op_ror;
  logic [3:0] eff;
  logic [7:0] rev_operand, rev_work;
  assign op_sll = OPCODE == 2'b00;
  assign op_ror = OPCODE == 2'b11;
  // Shifts saturate at 8 (everything shifted out); rotates wrap modulo 8.
  assign eff = op_ror ? {1'b0, AMOUNT[2:0]} : (AMOUNT > 8'd8 ? 4'd8 : AMOUNT[3:0]);
  assign accept = START && (state_q == IDLE || state_q == FIN);
  assign rev_operand = {<<{OPERAND}};
  assign rev_work = {<<{work_q}};
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    s_d = s_q;
    a_d = a_q;
    c_d = c_q;
    two_d = two_q;
    sll_d = sll_q;
    result_d = result_q;
    done_d = 1'b0;
    if (state_q == PASS1 || state_q == PASS2) work_d = ROT_RESULT;
    if (state_q == PASS1) begin
      state_d = two_q ? PASS2 : FIN;
      s_d = two_q ? 3'd1 : s_q;
    end
    if (state_q == PASS2) state_d = FIN;
    if (state_q == FIN) begin
      result_d = sll_q ? rev_work : work_q;
      done_d = 1'b1;
      state_d = IDLE;
    end
    // Left shifts run as right shifts on the bit-reversed value; an amount of 8 needs 7 then 1.
    if (accept) begin
      work_d = op_sll ? rev_operand : OPERAND;
      s_d = eff[3] ? 3'd7 : eff[2:0];
      a_d = OPCODE == 2'b10;
      c_d = op_ror;
      two_d = eff[3];
      sll_d = op_sll;
      state_d = eff == 4'd0 ? FIN : PASS1;
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      work_q <= 8'h00;
      result_q <= 8'h00;
      s_q <= 3'd0;
      a_q <= 1'b0;
      c_q <= 1'b0;
      two_q <= 1'b0;
      sll_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      result_q <= result_d;
      s_q <= s_d;
      a_q <= a_d;
      c_q <= c_d;
      two_q <= two_d;
      sll_q <= sll_d;
      done_q <= done_d;
    end
  end
  assign ROT_DATA = work_q;
  assign ROT_S = s_q;
  assign ROT_A = a_q;
  assign ROT_C = c_q;
  assign BUSY = state_q == PASS1 || state_q == PASS2;
  assign DONE = done_q;
  assign RESULT = result_q;
`ifdef SHIFT_ZERO_FLAG_EN
  logic zero_q, zero_d;
  always_comb zero_d = state_q == FIN ? result_d == 8'h00 : zero_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) zero_q <= 1'b0;
    else zero_q <= zero_d;
  end
  assign ZERO = zero_q;
`else
  assign ZERO = 1'b0;
`endif
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed test-plan cases plus random ops against an arithmetic reference,
// with a behavioural stand-in for the rotator.
module tb_shift_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] opcode = 2'd0;
  logic [7:0] operand = 8'h00, amount = 8'h00, rot_out;
  logic [7:0] rot_data, result;
  logic [2:0] rot_s;
  logic rot_a, rot_c, busy, done, zero;
  int total = 0, bad = 0;
  logic [7:0] held = 8'h00;
  bit zexp = 1'b0, pend = 1'b0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .OPCODE(opcode), .OPERAND(operand),
    .AMOUNT(amount), .ROT_RESULT(rot_out), .ROT_DATA(rot_data), .ROT_S(rot_s),
    .ROT_A(rot_a), .ROT_C(rot_c), .BUSY(busy), .DONE(done), .RESULT(result), .ZERO(zero)
  );

  // Rotator: right rotate when C, else right shift with sign or zero fill.
  logic [15:0] fill, dbl;
  always_comb begin
    fill = {rot_a ? {8{rot_data[7]}} : 8'h00, rot_data} >> rot_s;
    dbl = {rot_data, rot_data} >> rot_s;
    rot_out = rot_c ? dbl[7:0] : fill[7:0];
  end

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7 - i];
    return r;
  endfunction

  function automatic logic [7:0] ref_shift(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amt);
    int v, n, r, s;
    v = int'(x);
    n = amt > 8'd8 ? 8 : int'(amt);
    r = int'(amt) % 8;
    s = x[7] ? v - 256 : v;
    case (op)
      2'd0: return 8'((v << n) & 255);
      2'd1: return 8'(v >> n);
      2'd2: return 8'(s >>> n);
      default: return 8'(((v >> r) | (v << (8 - r))) & 255);
    endcase
  endfunction

  function automatic bit zero_of(input logic [7:0] e);
`ifdef SHIFT_ZERO_FLAG_EN
    return e == 8'h00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic launch(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amt);
    start = 1'b1;
    opcode = op;
    operand = x;
    amount = amt;
  endtask

  // Called at the negedge where START for this op is being driven.
  task automatic follow(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amt,
                        input bit noise, input bit chain,
                        input logic [1:0] nop, input logic [7:0] nx, input logic [7:0] namt);
    int eff, k;
    logic [7:0] e;
    eff = op == 2'd3 ? int'(amt) % 8 : (amt > 8'd8 ? 8 : int'(amt));
    k = eff == 0 ? 0 : (eff == 8 ? 2 : 1);
    e = ref_shift(op, x, amt);
    for (int n = 0; n <= k; n++) begin
      @(negedge clk);
      chk1("busy", busy, n < k);
      chk1("done", done, n == 0 && pend);
      chk8("result_held", result, held);
      chk1("zero_held", zero, zexp);
      if (n == 0) chk8("rot_data", rot_data, op == 2'd0 ? rev8(x) : x);
      if (n < k) begin
        chk8("rot_s", {5'b0, rot_s}, n == 0 ? (k == 2 ? 8'd7 : 8'(eff)) : 8'd1);
        chk1("rot_a", rot_a, op == 2'd2);
        chk1("rot_c", rot_c, op == 2'd3);
      end
      pend = 1'b0;
      opcode = 2'($urandom);
      operand = 8'($urandom);
      amount = 8'($urandom);
      start = n < k ? noise : 1'b0;
      if (n == k && chain) launch(nop, nx, namt);
    end
    held = e;
    zexp = zero_of(e);
    if (chain) pend = 1'b1;
    else begin
      @(negedge clk);
      chk1("done_pulse", done, 1'b1);
      chk8("result", result, e);
      chk1("zero", zero, zexp);
      chk1("busy_done", busy, 1'b0);
      @(negedge clk);
      chk1("done_width", done, 1'b0);
    end
  endtask

  initial begin
    logic [1:0] cop, nop;
    logic [7:0] cx, camt, nx, namt;
    bit ch;
    repeat (2) @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk8("rst_result", result, 8'h00);
    chk1("rst_zero", zero, 1'b0);
    chk8("rst_rot_data", rot_data, 8'h00);
    chk8("rst_rot_s", {5'b0, rot_s}, 8'h00);
    chk1("rst_rot_a", rot_a, 1'b0);
    chk1("rst_rot_c", rot_c, 1'b0);
    rst_n = 1'b1;
    launch(2'd1, 8'h51, 8'd3);   follow(2'd1, 8'h51, 8'd3, 0, 0, 0, 0, 0);
    launch(2'd0, 8'h51, 8'd3);   follow(2'd0, 8'h51, 8'd3, 0, 0, 0, 0, 0);
    launch(2'd0, 8'h01, 8'd9);   follow(2'd0, 8'h01, 8'd9, 0, 0, 0, 0, 0);
    launch(2'd2, 8'hB0, 8'd2);   follow(2'd2, 8'hB0, 8'd2, 0, 0, 0, 0, 0);
    launch(2'd2, 8'h90, 8'd200); follow(2'd2, 8'h90, 8'd200, 0, 0, 0, 0, 0);
    launch(2'd3, 8'h51, 8'd11);  follow(2'd3, 8'h51, 8'd11, 0, 0, 0, 0, 0);
    launch(2'd3, 8'h51, 8'd16);  follow(2'd3, 8'h51, 8'd16, 0, 0, 0, 0, 0);
    launch(2'd1, 8'h51, 8'd3);   follow(2'd1, 8'h51, 8'd3, 1, 0, 0, 0, 0);
    launch(2'd2, 8'h90, 8'd8);   follow(2'd2, 8'h90, 8'd8, 1, 0, 0, 0, 0);
    launch(2'd1, 8'h51, 8'd3);   follow(2'd1, 8'h51, 8'd3, 0, 1, 2'd0, 8'h51, 8'd3);
    follow(2'd0, 8'h51, 8'd3, 0, 1, 2'd3, 8'hC3, 8'd0);
    follow(2'd3, 8'hC3, 8'd0, 0, 0, 0, 0, 0);
    launch(2'd0, 8'h01, 8'd9);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk8("pass2_rot_s", {5'b0, rot_s}, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_done", done, 1'b0);
    chk8("arst_result", result, 8'h00);
    chk1("arst_zero", zero, 1'b0);
    chk8("arst_rot_data", rot_data, 8'h00);
    held = 8'h00;
    zexp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_done", done, 1'b0);
      chk1("post_rst_busy", busy, 1'b0);
      chk8("post_rst_result", result, 8'h00);
    end
    cop = 2'($urandom);
    cx = 8'($urandom);
    camt = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 10));
    launch(cop, cx, camt);
    for (int i = 0; i < 60; i++) begin
      nop = 2'($urandom);
      nx = $urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom);
      namt = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 10));
      ch = i < 59 && $urandom_range(0, 1) == 1;
      follow(cop, cx, camt, $urandom_range(0, 1) == 1, ch, nop, nx, namt);
      if (!ch && i < 59) launch(nop, nx, namt);
      cop = nop;
      cx = nx;
      camt = namt;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
